// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the timed data memory
//
// Purpose: state encoding for the request/response FSM, the word geometry
// constant and the byte-lane merge function shared by the data- and
// instruction-side memory models.
// Ports: none (package).

package mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Lane k takes the new byte when its enable is set, otherwise keeps the old byte.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0]           old_word,
    input logic [31:0]           wdata,
    input logic [WORD_BYTES-1:0] byteen
  );
    logic [31:0] w;
    w = old_word;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byteen[k]) begin
        w[8*k +: 8] = wdata[8*k +: 8];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// rtl/byte_merge.sv - combinational byte-lane write merge
//
// Purpose: produce the word that results from writing the enabled lanes of
// wdata_i over old_i.
// Ports:
//   old_i     in  32  current word content
//   wdata_i   in  32  lane-aligned store data
//   byteen_i  in  4   byte lanes to replace
//   merged_o  out 32  merged word

module byte_merge
  import mem_pkg::*;
(
  input  logic [31:0]           old_i,
  input  logic [31:0]           wdata_i,
  input  logic [WORD_BYTES-1:0] byteen_i,
  output logic [31:0]           merged_o
);

  assign merged_o = merge_bytes(old_i, wdata_i, byteen_i);

endmodule

// File: rtl/timed_data_mem.sv
// rtl/timed_data_mem.sv - request/response data memory with fixed access latency
//
// Purpose: word-organised data memory with configurable depth, base address
// and latency, byte-enable store merge, out-of-range error response and a
// committed-store counter. One transaction in flight at a time.
// Ports:
//   clk          in  1   clock
//   reset        in  1   synchronous, active-high reset
//   req_valid    in  1   request present
//   req_ready    out 1   block can accept a request
//   req_addr     in  AW  byte address, bits [1:0] ignored
//   req_wdata    in  32  lane-aligned store data
//   req_byteen   in  4   lanes to write, 0 = load
//   resp_valid   out 1   response available
//   resp_ready   in  1   consumer accepts the response
//   resp_rdata   out 32  word read (pre-store word for stores)
//   resp_err     out 1   address was out of range
//   store_count  out 32  committed in-range stores

module timed_data_mem
  import mem_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DEPTH   = 4096,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AW-1:0]         req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [WORD_BYTES-1:0] req_byteen,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [31:0]           store_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [AW-1:0] BASE_A   = AW'(BASE);
  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [31:0]             wdata_q;
  logic [WORD_BYTES-1:0]   byteen_q;
  logic                    in_range_q;
  logic [31:0]             resp_rdata_q;
  logic                    resp_err_q;
  logic [31:0]             store_count_q;
  logic [31:0]             mem_q [DEPTH];

  logic [AW-1:0]           off_d;
  logic [AW-1:0]           word_off_d;
  logic                    in_range_d;
  logic [31:0]             old_word_d;
  logic [31:0]             merged_d;

  // Offset wraps modulo 2^AW; the explicit >= BASE test rejects addresses
  // below the window that would otherwise wrap into a small index.
  assign off_d      = req_addr - BASE_A;
  assign word_off_d = off_d >> 2;
  assign in_range_d = (req_addr >= BASE_A) && (word_off_d < DEPTH_A);

  assign old_word_d = mem_q[idx_q];

  byte_merge u_merge (
    .old_i    (old_word_d),
    .wdata_i  (wdata_q),
    .byteen_i (byteen_q),
    .merged_o (merged_d)
  );

  // req_ready is gated by reset so it is low during reset and high in the
  // very first cycle after reset drops, without waiting an extra edge.
  assign req_ready   = (state_q == ST_IDLE) && !reset;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign store_count = store_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      byteen_q      <= '0;
      in_range_q    <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      store_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            idx_q      <= word_off_d[IW-1:0];
            wdata_q    <= req_wdata;
            byteen_q   <= req_byteen;
            in_range_q <= in_range_d;
            cnt_q      <= CNT_INIT;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // Read and write share this edge: rdata gets the pre-store word.
            resp_rdata_q <= in_range_q ? old_word_d : 32'h0;
            resp_err_q   <= !in_range_q;
            if (in_range_q && (byteen_q != '0)) begin
              mem_q[idx_q]  <= merged_d;
              store_count_q <= store_count_q + 32'd1;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timed_data_mem.sv
// tb/tb_timed_data_mem.sv - directed self-checking bench for timed_data_mem

module tb_timed_data_mem;

  logic        clk = 1'b0;
  logic        rst        [4];
  logic        req_valid  [4];
  logic        req_ready  [4];
  logic [31:0] req_addr   [4];
  logic [31:0] req_wdata  [4];
  logic [3:0]  req_byteen [4];
  logic        resp_valid [4];
  logic        resp_ready [4];
  logic [31:0] resp_rdata [4];
  logic        resp_err   [4];
  logic [31:0] store_cnt  [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // u0: LATENCY=1; u1: LATENCY=3; u2: BASE=0x1000 DEPTH=16 LATENCY=2; u3: LATENCY=4
  timed_data_mem #(.AW(32), .DEPTH(64), .BASE(32'h0), .LATENCY(1)) u0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_byteen(req_byteen[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .store_count(store_cnt[0]));
  timed_data_mem #(.AW(32), .DEPTH(64), .BASE(32'h0), .LATENCY(3)) u1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_byteen(req_byteen[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .store_count(store_cnt[1]));
  timed_data_mem #(.AW(32), .DEPTH(16), .BASE(32'h0000_1000), .LATENCY(2)) u2 (
    .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_byteen(req_byteen[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .store_count(store_cnt[2]));
  timed_data_mem #(.AW(32), .DEPTH(64), .BASE(32'h0), .LATENCY(4)) u3 (
    .clk(clk), .reset(rst[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .req_addr(req_addr[3]), .req_wdata(req_wdata[3]), .req_byteen(req_byteen[3]),
    .resp_valid(resp_valid[3]), .resp_ready(resp_ready[3]), .resp_rdata(resp_rdata[3]),
    .resp_err(resp_err[3]), .store_count(store_cnt[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; lat counts edges from acceptance to resp_valid.
  task automatic do_req(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata,
                        output logic err, output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; rdata = '0; err = 1'b0; n = 0;
    req_addr[k] = addr; req_wdata[k] = wdata; req_byteen[k] = be; req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 50) begin tick(); n++; end
    if (!req_ready[k]) begin req_valid[k] = 1'b0; ok = 1'b0; return; end
    tick();
    req_valid[k] = 1'b0;
    while (!resp_valid[k] && lat < 50) begin tick(); lat++; end
    if (!resp_valid[k]) begin ok = 1'b0; return; end
    rdata = resp_rdata[k]; err = resp_err[k];
    resp_ready[k] = 1'b1;
    tick();
    resp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) rst[k] = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (req_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_req_ready[%0d]: got %b want 0", k, req_ready[k]); end
      checks++;
      if (resp_valid[k] !== 1'b0 || resp_err[k] !== 1'b0 || resp_rdata[k] !== 32'h0 || store_cnt[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got v=%b e=%b d=%h c=%0d want 0 0 0 0", k, resp_valid[k], resp_err[k], resp_rdata[k], store_cnt[k]);
      end
    end
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (req_ready[k] !== 1'b1) begin errors++; $display("FAIL post_reset_ready[%0d]: got %b want 1", k, req_ready[k]); end
    end
  endtask

  task automatic test_load_after_reset();
    logic [31:0] d; logic e; int lat; bit ok;
    do_req(0, 32'h10, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || lat != 1) begin errors++; $display("FAIL load_reset_latency: got ok=%0d lat=%0d want 1 1", ok, lat); end
    checks++;
    if (d !== 32'h0 || e !== 1'b0 || store_cnt[0] !== 32'h0) begin
      errors++; $display("FAIL load_reset_data: got d=%h e=%b c=%0d want 0 0 0", d, e, store_cnt[0]);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat; bit ok;
    do_req(1, 32'h20, 32'hDEAD_BEEF, 4'hF, d, e, lat, ok);
    checks++;
    if (!ok || lat != 3 || d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL store_resp: got ok=%0d lat=%0d d=%h e=%b want 1 3 0 0", ok, lat, d, e);
    end
    checks++;
    if (store_cnt[1] !== 32'd1) begin errors++; $display("FAIL store_count_1: got %0d want 1", store_cnt[1]); end
    do_req(1, 32'h20, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || lat != 3 || d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++; $display("FAIL load_back: got ok=%0d lat=%0d d=%h e=%b want 1 3 deadbeef 0", ok, lat, d, e);
    end
  endtask

  task automatic test_partial_merge();
    logic [31:0] d; logic e; int lat; bit ok;
    do_req(1, 32'h40, 32'h1122_3344, 4'hF, d, e, lat, ok);
    do_req(1, 32'h40, 32'hAABB_CCDD, 4'b0101, d, e, lat, ok);
    checks++;
    if (!ok || d !== 32'h1122_3344) begin errors++; $display("FAIL merge_old_word: got ok=%0d d=%h want 11223344", ok, d); end
    do_req(1, 32'h40, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || d !== 32'h11BB_33DD) begin errors++; $display("FAIL merge_result: got ok=%0d d=%h want 11bb33dd", ok, d); end
    do_req(1, 32'h43, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || d !== 32'h11BB_33DD) begin errors++; $display("FAIL misaligned_load: got ok=%0d d=%h want 11bb33dd", ok, d); end
    checks++;
    if (store_cnt[1] !== 32'd3) begin errors++; $display("FAIL store_count_3: got %0d want 3", store_cnt[1]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e; int lat; bit ok;
    do_req(2, 32'h1000, 32'h1234_5678, 4'hF, d, e, lat, ok);
    checks++;
    if (!ok || lat != 2 || e !== 1'b0 || store_cnt[2] !== 32'd1) begin
      errors++; $display("FAIL oor_setup: got ok=%0d lat=%0d e=%b c=%0d want 1 2 0 1", ok, lat, e, store_cnt[2]);
    end
    do_req(2, 32'h0FFC, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_below: got ok=%0d e=%b d=%h want 1 1 0", ok, e, d); end
    do_req(2, 32'h1040, 32'hFFFF_FFFF, 4'hF, d, e, lat, ok);
    checks++;
    if (!ok || e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL oor_above_store: got ok=%0d e=%b d=%h want 1 1 0", ok, e, d); end
    checks++;
    if (store_cnt[2] !== 32'd1) begin errors++; $display("FAIL oor_count: got %0d want 1", store_cnt[2]); end
    do_req(2, 32'h1000, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || e !== 1'b0 || d !== 32'h1234_5678) begin errors++; $display("FAIL oor_word0: got ok=%0d e=%b d=%h want 1 0 12345678", ok, e, d); end
    do_req(2, 32'h103C, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || e !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL oor_last_word: got ok=%0d e=%b d=%h want 1 0 0", ok, e, d); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] d; logic e; int lat; bit ok; int n;
    do_req(0, 32'h8, 32'hCAFE_F00D, 4'hF, d, e, lat, ok);
    req_addr[0] = 32'h8; req_byteen[0] = 4'h0; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 50) begin tick(); n++; end
    checks++;
    if (!resp_valid[0]) begin errors++; $display("FAIL bp_resp_timeout: got resp_valid=0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (resp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || resp_rdata[0] !== 32'hCAFE_F00D || resp_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h e=%b want 1 0 cafef00d 0", i, resp_valid[0], req_ready[0], resp_rdata[0], resp_err[0]);
      end
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got r=%b v=%b want 1 0", req_ready[0], resp_valid[0]);
    end
    req_addr[0] = 32'h8; req_byteen[0] = 4'h0; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept: got r=%b v=%b want 0 0", req_ready[0], resp_valid[0]);
    end
    tick();
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL bp_next_resp: got v=%b d=%h want 1 cafef00d", resp_valid[0], resp_rdata[0]);
    end
    resp_ready[0] = 1'b1;
    tick();
    resp_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat; bit ok;
    req_addr[3] = 32'h8; req_wdata[3] = 32'h7777_7777; req_byteen[3] = 4'hF; req_valid[3] = 1'b1;
    checks++;
    if (req_ready[3] !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b want 1", req_ready[3]); end
    tick();
    req_valid[3] = 1'b0;
    tick();
    tick();
    rst[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid[3] !== 1'b0) begin errors++; $display("FAIL rmw_no_resp[%0d]: got %b want 0", i, resp_valid[3]); end
    end
    rst[3] = 1'b0;
    #1;
    checks++;
    if (store_cnt[3] !== 32'd0) begin errors++; $display("FAIL rmw_count: got %0d want 0", store_cnt[3]); end
    do_req(3, 32'h8, 32'h0, 4'h0, d, e, lat, ok);
    checks++;
    if (!ok || lat != 4 || d !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL rmw_load: got ok=%0d lat=%0d d=%h e=%b want 1 4 0 0", ok, lat, d, e);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      req_byteen[k] = '0; resp_ready[k] = 1'b0;
    end
    test_reset();
    test_load_after_reset();
    test_store_load();
    test_partial_merge();
    test_out_of_range();
    test_back_pressure();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timed_data_mem.md
Name: timed_data_mem

Overview:
- Parametrised, synthesizable data-memory model for the P7 CPU system bench and FPGA bring-up.
- Replaces the zero-latency combinational data array with a request/response memory. The memory has:
  - configurable depth, base address and access latency;
  - byte-enable write merge;
  - an out-of-range error response;
  - a committed-store counter.
- Sits between the CPU's memory-stage port (via a stall adapter) and the rest of the bench.

Parameters:
- AW, 32, address width in bits.
- DEPTH, 4096, number of 32-bit words. Must be a power of two, at least 2.
- BASE, 32'h0000_0000, byte address of word 0. Must be word-aligned.
- LATENCY, 1, cycles from request acceptance to response valid. Must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  AW  byte address; bits [1:0] are ignored
- req_wdata  in  32  store data, already lane-aligned
- req_byteen  in  4  byte lanes to write; 0 means a load
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  word read; for a store, the word before the store
- resp_err  out  1  address was out of range
- store_count  out  32  number of committed in-range stores

Behaviour:
- Reset:
  - state goes to IDLE.
  - req_ready=0 during reset. After reset deasserts, req_ready=1 in the first cycle.
  - resp_valid=0, resp_rdata=0, resp_err=0, store_count=0.
  - All DEPTH words are cleared to 0.
- Address mapping:
  - off = req_addr - BASE, computed modulo 2^AW.
  - idx = off >> 2.
  - In range iff req_addr >= BASE and idx < DEPTH.
- State IDLE:
  - req_ready=1, resp_valid=0.
  - On req_valid&req_ready at edge T: latch addr, wdata, byteen and the in-range flag; load cnt=LATENCY-1; go to WAIT.
- State WAIT:
  - req_ready=0, resp_valid=0.
  - If cnt!=0: decrement cnt.
  - If cnt==0, at that edge: capture resp_rdata = mem[idx], or 0 if out of range; set resp_err = !in_range.
  - If in range and byteen!=0: write the merged word. Lane k takes wdata byte k when byteen[k]=1, otherwise keeps the old byte. Increment store_count, wrapping at 2^32.
  - Go to RESP.
  - Result: resp_valid is first visible after edge T+LATENCY.
- State RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_valid&resp_ready.
  - On resp_valid&resp_ready: go to IDLE.
  - A new request is not accepted in the same cycle as the response handshake. Minimum spacing between acceptances is LATENCY+2 cycles.
- Out-of-range store:
  - No array write; store_count is unchanged.
  - resp_err=1, resp_rdata=0.
- Misaligned address: bits [1:0] are silently dropped and the word is accessed.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is discarded and no write occurs.
  - Reset clears the array anyway.
- req_valid while req_ready=0 is ignored. The requester must hold its request until it is accepted.
- resp_rdata is registered; there is no combinational path from req_* to resp_*.

Decomposition:
- Shared package mem_pkg holds:
  - the state encoding (IDLE, WAIT, RESP);
  - the function merge_bytes(old, wdata, byteen), returning a 32-bit word;
  - the constant WORD_BYTES=4.
- One natural sub-module, byte_merge: combinational lane merge, reusable by the instruction-side model.
- The FSM, latency counter and array stay in timed_data_mem.

Test Plan:
- Load after reset, LATENCY=1 → IDLE request: addr=0x10, byteen=0 accepted at edge T → resp_valid high after T+1; resp_rdata=0, resp_err=0, store_count=0.
- Full store then load, LATENCY=3 → store 0xDEADBEEF to 0x20 with byteen=4'hF → store's resp_rdata=0, store_count=1; then load 0x20 → resp_rdata=0xDEADBEEF, response 3 cycles after acceptance.
- Partial merge → word 0x11223344 at 0x40, then store wdata=0xAABBCCDD with byteen=4'b0101 → next load of 0x40 returns 0x11BB33DD.
- Out of range, BASE=0x1000, DEPTH=16 → load 0x0FFC and store 0x1040 both return resp_err=1 and resp_rdata=0; store_count unchanged; word 0 is unchanged.
- Back-pressure → resp_ready held low for 5 cycles → resp_valid stays 1 with stable data and req_ready=0 throughout; handshake then returns to IDLE, and the next request is accepted the following cycle.
- Reset mid-WAIT, LATENCY=4 → store to 0x8 accepted, reset asserted 2 cycles later → no response; store_count=0; a load of 0x8 after reset returns 0.
